bin2bcd_seq: RTL and testbench

Sequential binary-to-BCD converter that sits directly downstream of the 4-bit array multiplier in the arithmetic calculator. It accepts the 8-bit product `pro[7:0]` through a valid/ready handshake. It converts the product to packed BCD digits using the shift-add-3 (double-dabble) algorithm, one bit per clock. It then presents the digits to the display/decoder stage through a second valid/ready handshake.

---
 rtl/bin2bcd_seq.sv | 75 +++++++
 tb/tb_bin2bcd_seq.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double-dabble, one bit per clock) with
// valid/ready handshakes on both the binary input and the packed BCD output.
module bin2bcd_seq #(
  parameter int IN_W   = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_W-1:0]       bin,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int CW = $clog2(IN_W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t              state, state_nxt;
  logic [CW-1:0]       cnt;
  logic [IN_W-1:0]     bin_q;
  logic [4*DIGITS-1:0] scr, scr_adj, scr_sh;

  // Per-digit add-3 correction; digits are independent, no carry between them.
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    assign scr_adj[4*g +: 4] = (scr[4*g +: 4] >= 4'd5) ? scr[4*g +: 4] + 4'd3
                                                         : scr[4*g +: 4];
  end

  assign scr_sh = {scr_adj[4*DIGITS-2:0], bin_q[IN_W-1]};

  // Handshake flags come straight from the state register: no input paths.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == HOLD);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)          state_nxt = SHIFT;
      SHIFT:   if (cnt == CW'(1))     state_nxt = HOLD;
      HOLD:    if (out_ready)         state_nxt = IDLE;
      default:                        state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      bin_q <= '0;
      scr   <= '0;
      bcd   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (in_valid) begin
          bin_q <= bin;
          scr   <= '0;
          cnt   <= CW'(IN_W);
        end
        SHIFT: begin
          scr   <= scr_sh;
          bin_q <= {bin_q[IN_W-2:0], 1'b0};
          cnt   <= cnt - CW'(1);
          // Last shift: publish the finished digits into the output register.
          if (cnt == CW'(1)) bcd <= scr_sh;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed self-checking bench for bin2bcd_seq (IN_W=8, DIGITS=3).
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  bin = '0;
  logic [11:0] bcd;
  logic        out_valid;
  logic        out_ready = 1'b1;

  int checks = 0;
  int errors = 0;

  bin2bcd_seq #(.IN_W(8), .DIGITS(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .bin(bin), .bcd(bcd), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] ref_bcd(input int v);
    ref_bcd = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Stimulus only: offer v, return latency (posedges from accept to first
  // out_valid sample), captured bcd and number of sampled in_ready-low cycles.
  task automatic do_conv(input logic [7:0] v, output int lat,
                         output logic [11:0] res, output int lo);
    int w = 0;
    while (!in_ready && w < 40) begin @(posedge clk); #1; w++; end
    in_valid = 1'b1; bin = v;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = -1; res = 12'hfff; lo = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (!in_ready) lo++;
      if (out_valid) begin lat = k; res = bcd; break; end
    end
  endtask

  task automatic test_reset();
    #2;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (bcd !== 12'h000) begin errors++; $display("FAIL reset_bcd got %h want 000", bcd); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_zero();
    int lat, lo; logic [11:0] res;
    out_ready = 1'b1;
    do_conv(8'd0, lat, res, lo);
    checks++; if (lat !== 8) begin errors++; $display("FAIL zero_latency got %0d want 8", lat); end
    checks++; if (res !== 12'h000) begin errors++; $display("FAIL zero_bcd got %h want 000", res); end
    checks++; if (lo !== 8) begin errors++; $display("FAIL zero_ready_low got %0d want 8", lo); end
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL zero_after_hs got rdy=%b ov=%b want rdy=1 ov=0", in_ready, out_valid);
    end
  endtask

  task automatic test_products();
    logic [7:0]  vals [5] = '{8'd225, 8'd255, 8'd99, 8'd100, 8'd9};
    logic [11:0] exps [5] = '{12'h225, 12'h255, 12'h099, 12'h100, 12'h009};
    int lat, lo; logic [11:0] res;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      do_conv(vals[i], lat, res, lo);
      checks++; if (res !== exps[i]) begin errors++; $display("FAIL product_%0d got %h want %h", vals[i], res, exps[i]); end
      checks++; if (res[3:0] > 4'd9 || res[7:4] > 4'd9 || res[11:8] > 4'd9) begin
        errors++; $display("FAIL digit_range_%0d got %h want each digit <= 9", vals[i], res);
      end
      checks++; if (lat !== 8) begin errors++; $display("FAIL product_lat_%0d got %0d want 8", vals[i], lat); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int lat, lo; logic [11:0] res;
    out_ready = 1'b0;
    do_conv(8'd144, lat, res, lo);
    checks++; if (res !== 12'h144) begin errors++; $display("FAIL bp_bcd got %h want 144", res); end
    for (int i = 0; i < 6; i++) begin
      if (i == 1) begin in_valid = 1'b1; bin = 8'd7; end
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1 || bcd !== 12'h144 || in_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold_%0d got ov=%b bcd=%h rdy=%b want ov=1 bcd=144 rdy=0", i, out_valid, bcd, in_ready);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || bcd !== 12'h144) begin
      errors++; $display("FAIL bp_release got rdy=%b ov=%b bcd=%h want rdy=1 ov=0 bcd=144", in_ready, out_valid, bcd);
    end
  endtask

  task automatic test_back_to_back();
    int c = 0, nacc = 0, nres = 0, hs = -1;
    int acc [2] = '{-1, -1};
    logic [11:0] r [2] = '{12'hfff, 12'hfff};
    logic pr, pv, piv;
    out_ready = 1'b1;
    in_valid = 1'b1; bin = 8'd12;
    for (int i = 0; i < 60 && nres < 2; i++) begin
      pr = in_ready; pv = out_valid; piv = in_valid;
      @(posedge clk); c++; #1;
      if (pr && piv && nacc < 2) begin
        acc[nacc] = c; nacc++;
        if (nacc == 1) bin = 8'd56; else in_valid = 1'b0;
      end
      if (pv && hs < 0) hs = c;
      if (out_valid) begin r[nres] = bcd; nres++; end
    end
    in_valid = 1'b0;
    checks++; if (nres !== 2) begin errors++; $display("FAIL b2b_results got %0d want 2", nres); end
    checks++; if (r[0] !== 12'h012) begin errors++; $display("FAIL b2b_first got %h want 012", r[0]); end
    checks++; if (r[1] !== 12'h056) begin errors++; $display("FAIL b2b_second got %h want 056", r[1]); end
    checks++; if (acc[1] !== hs + 1) begin errors++; $display("FAIL b2b_accept_after_hs got %0d want %0d", acc[1], hs + 1); end
    checks++; if (acc[1] - acc[0] !== 10) begin errors++; $display("FAIL b2b_spacing got %0d want 10", acc[1] - acc[0]); end
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset();
    int lat, lo; logic [11:0] res;
    out_ready = 1'b1;
    in_valid = 1'b1; bin = 8'd200;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL arst_busy got rdy=%b want 0", in_ready); end
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || bcd !== 12'h000 || in_ready !== 1'b1) begin
      errors++; $display("FAIL arst_immediate got ov=%b bcd=%h rdy=%b want ov=0 bcd=000 rdy=1", out_valid, bcd, in_ready);
    end
    #2 rst = 1'b0;
    do_conv(8'd37, lat, res, lo);
    checks++; if (res !== 12'h037) begin errors++; $display("FAIL arst_followup got %h want 037", res); end
    checks++; if (lat !== 8) begin errors++; $display("FAIL arst_followup_lat got %0d want 8", lat); end
    @(posedge clk); #1;
  endtask

  task automatic test_sweep();
    int lat, lo; logic [11:0] res, exp_v;
    out_ready = 1'b1;
    for (int v = 0; v < 256; v++) begin
      exp_v = ref_bcd(v);
      do_conv(8'(v), lat, res, lo);
      checks++; if (res !== exp_v) begin errors++; $display("FAIL sweep_%0d got %h want %h", v, res, exp_v); end
      checks++; if (lat !== 8) begin errors++; $display("FAIL sweep_lat_%0d got %0d want 8", v, lat); end
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_products();
    test_backpressure();
    test_back_to_back();
    test_async_reset();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
